ntru_encrypt_seq: RTL

Coefficient-serial NTRU-HRSS encryption core: computes c = r·h + b in Z_q[x]/(x^N − 1), with q = 2^LOG_Q. It is the parametrised, sequential successor to the fully parallel lift/multiply/add datapath. Inputs arrive as a streamed coefficient load, a fixed N-cycle rotating-accumulator multiply follows, and results leave through a back-pressured output stream. It sits between the lift stage (which supplies b) and the Rq packer (which consumes c).

---
 rtl/ntru_encrypt_seq_if.sv | 25 ++
 rtl/ntru_encrypt_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ntru_encrypt_seq_if.sv
// Load and result stream bundle for the coefficient-serial NTRU encryption core.
// The master side feeds r/h/b coefficients and consumes c coefficients.
interface ntru_encrypt_seq_if #(
    parameter int LOG_Q = 13
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_r;
    logic [LOG_Q-1:0] in_h;
    logic [LOG_Q-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [LOG_Q-1:0] out_c;
    logic             out_last;

    modport master (
        output in_valid, in_r, in_h, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_last
    );

    modport slave (
        input  in_valid, in_r, in_h, in_b, out_ready,
        output in_ready, out_valid, out_c, out_last
    );
endinterface

// File: rtl/ntru_encrypt_seq.sv
// Coefficient-serial NTRU-HRSS encryption: c = r*h + b in Z_q[x]/(x^N - 1), q = 2^LOG_Q.
// Streamed load, N-cycle rotating-accumulator multiply, back-pressured result drain.
module ntru_encrypt_seq #(
    parameter int N     = 701,
    parameter int LOG_Q = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    ntru_encrypt_seq_if.slave    bus,
    output logic                 busy,
    output logic                 done
);
    localparam int IDX_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, MUL, DRAIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             mode_q;
    logic             in_fire;
    logic             out_fire;
    logic             idx_last;

    logic [1:0]       rbuf [N];
    logic [LOG_Q-1:0] hrot [N];
    logic [LOG_Q-1:0] acc  [N];

    // Ternary multiply-accumulate: +1 adds, -1 subtracts, codes 00/10 leave acc alone.
    function automatic logic [LOG_Q-1:0] mac_step(input logic [LOG_Q-1:0] a,
                                                  input logic [LOG_Q-1:0] h,
                                                  input logic [1:0]       r);
        case (r)
            2'b01:   mac_step = a + h;
            2'b11:   mac_step = a - h;
            default: mac_step = a;
        endcase
    endfunction

    assign in_fire  = bus.in_valid  & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;
    assign idx_last = (idx == IDX_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                state_nxt = LOAD;
            LOAD:    if (in_fire && idx_last)  state_nxt = MUL;
            MUL:     if (idx_last)             state_nxt = DRAIN;
            DRAIN:   if (out_fire && idx_last) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == LOAD);
        bus.out_valid = (state == DRAIN);
        bus.out_last  = (state == DRAIN) && idx_last;
        bus.out_c     = (state == DRAIN) ? acc[0] : '0;
        busy          = (state != IDLE);
    end

    // Control: beat/cycle counter, latched mode, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            mode_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_fire && idx_last;
            case (state)
                IDLE:    if (start) begin
                             idx    <= '0;
                             mode_q <= mode;
                         end
                LOAD:    if (in_fire)  idx <= idx_last ? '0 : idx + IDX_W'(1);
                MUL:                   idx <= idx_last ? '0 : idx + IDX_W'(1);
                DRAIN:   if (out_fire) idx <= idx_last ? '0 : idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Operand buffers carry no reset; their contents only matter after a full load.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int k = 0; k < N - 1; k++) begin
                rbuf[k] <= rbuf[k+1];
                hrot[k] <= hrot[k+1];
            end
            rbuf[N-1] <= bus.in_r;
            hrot[N-1] <= bus.in_h;
        end else if (state == MUL) begin
            for (int k = 0; k < N - 1; k++) rbuf[k] <= rbuf[k+1];
            rbuf[N-1] <= 2'b00;
            hrot[0]   <= hrot[N-1];
            for (int k = 1; k < N; k++) hrot[k] <= hrot[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) acc[k] <= '0;
        end else begin
            case (state)
                LOAD: if (in_fire) begin
                    for (int k = 0; k < N - 1; k++) acc[k] <= acc[k+1];
                    acc[N-1] <= mode_q ? bus.in_b : '0;
                end
                MUL: begin
                    for (int k = 0; k < N; k++) acc[k] <= mac_step(acc[k], hrot[k], rbuf[0]);
                end
                DRAIN: if (out_fire) begin
                    for (int k = 0; k < N - 1; k++) acc[k] <= acc[k+1];
                    acc[N-1] <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
